bus_slave_mux_reg: RTL and testbench

//  Parametrised, registered read-return multiplexer between SLAVE_N bus slaves and the bus master.

---
 rtl/bus_slave_mux_reg.sv | 117 +++++++++++
 tb/tb_bus_slave_mux_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_mux_reg.sv
// Registered read-return mux for SLAVE_N bus slaves with a per-access watchdog.
// Locks one slave per access, returns its data or a timeout error for one cycle.
module bus_slave_mux_reg #(
    parameter int SLAVE_N = 8,
    parameter int DATA_W  = 32,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255,
    localparam int SEL_W  = $clog2(SLAVE_N)
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic [SLAVE_N-1:0]        s_cs_,
    input  logic [SLAVE_N*DATA_W-1:0] s_rd_data,
    input  logic [SLAVE_N-1:0]        s_rdy_,
    output logic [DATA_W-1:0]         m_rd_data,
    output logic                      m_rdy_,
    output logic                      m_err,
    output logic [SEL_W-1:0]          m_sel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t            state;
    state_t            state_nx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  cnt_nx;
    logic [SEL_W-1:0]  sel_nx;
    logic [SEL_W-1:0]  pick;
    logic [DATA_W-1:0] data_nx;
    logic              rdy_nx;
    logic              err_nx;
    logic              any_cs;
    logic              sel_cs;
    logic              sel_rdy;
    logic [DATA_W-1:0] sel_data;

    assign any_cs   = ~&s_cs_;
    assign sel_cs   = s_cs_[m_sel];
    assign sel_rdy  = s_rdy_[m_sel];
    assign sel_data = s_rd_data[m_sel*DATA_W +: DATA_W];

    // Fixed priority: lowest asserted chip-select wins.
    always_comb begin
        pick = '0;
        for (int i = SLAVE_N - 1; i >= 0; i--) begin
            if (!s_cs_[i]) begin
                pick = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = tmo_cnt;
        sel_nx   = m_sel;
        data_nx  = m_rd_data;
        err_nx   = m_err;
        rdy_nx   = 1'b1;
        unique case (state)
            IDLE: begin
                if (any_cs) begin
                    state_nx = WAIT;
                    sel_nx   = pick;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                if (sel_cs) begin
                    state_nx = IDLE;
                end else if (!sel_rdy) begin
                    state_nx = RESP;
                    data_nx  = sel_data;
                    err_nx   = 1'b0;
                    rdy_nx   = 1'b0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = RESP;
                    data_nx  = '0;
                    err_nx   = 1'b1;
                    rdy_nx   = 1'b0;
                end else if (tmo_cnt != '1) begin
                    cnt_nx = tmo_cnt + 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            m_sel     <= '0;
            m_rd_data <= '0;
            m_err     <= 1'b0;
            m_rdy_    <= 1'b1;
        end else begin
            state     <= state_nx;
            tmo_cnt   <= cnt_nx;
            m_sel     <= sel_nx;
            m_rd_data <= data_nx;
            m_err     <= err_nx;
            m_rdy_    <= rdy_nx;
        end
    end

endmodule

// File: tb/tb_bus_slave_mux_reg.sv
// Directed and randomized check of bus_slave_mux_reg against a
// transaction-level reference model.
module tb_bus_slave_mux_reg;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            reset_;
    logic [N-1:0]    s_cs_;
    logic [N*DW-1:0] s_rd_data;
    logic [N-1:0]    s_rdy_;
    logic [DW-1:0]   m_rd_data;
    logic            m_rdy_;
    logic            m_err;
    logic [2:0]      m_sel;

    int total = 0;
    int bad   = 0;

    bus_slave_mux_reg #(
        .SLAVE_N(N),
        .DATA_W (DW),
        .TMO_W  (8),
        .TMO_CYC(TMO)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .s_cs_    (s_cs_),
        .s_rd_data(s_rd_data),
        .s_rdy_   (s_rdy_),
        .m_rd_data(m_rd_data),
        .m_rdy_   (m_rdy_),
        .m_err    (m_err),
        .m_sel    (m_sel)
    );

    always #5 clk = ~clk;

    // Reference model: one access at a time, counted in whole WAIT cycles.
    bit          locked;
    bit          responding;
    int          waits;
    int          msel;
    logic [31:0] mdata;
    bit          merr;
    bit          mrdy;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic [N-1:0] cs,
                         input logic [N-1:0] rdy, input logic [N*DW-1:0] d);
        if (!rst) begin
            locked = 0; responding = 0; waits = 0; msel = 0;
            mdata = 0; merr = 0; mrdy = 1;
            return;
        end
        mrdy = 1;
        if (responding) begin
            responding = 0;
        end else if (locked) begin
            waits++;
            if (cs[msel]) begin
                locked = 0;
            end else if (!rdy[msel]) begin
                mdata = d[msel*DW +: DW]; merr = 0;
                locked = 0; responding = 1; mrdy = 0;
            end else if (waits == TMO) begin
                mdata = 0; merr = 1;
                locked = 0; responding = 1; mrdy = 0;
            end
        end else if (cs != '1) begin
            bit found = 0;
            for (int i = 0; i < N; i++) begin
                if (!cs[i] && !found) begin
                    msel = i; found = 1;
                end
            end
            locked = 1; waits = 0;
        end
    endtask

    task automatic compare_model();
        chk("rdy",  {63'd0, m_rdy_}, {63'd0, mrdy});
        chk("data", {32'd0, m_rd_data}, {32'd0, mdata});
        chk("err",  {63'd0, m_err}, {63'd0, merr});
        chk("sel",  {61'd0, m_sel}, 64'(msel));
    endtask

    task automatic step(input logic rst, input logic [N-1:0] cs,
                        input logic [N-1:0] rdy, input logic [N*DW-1:0] d);
        @(negedge clk);
        compare_model();
        reset_ = rst; s_cs_ = cs; s_rdy_ = rdy; s_rd_data = d;
        model(rst, cs, rdy, d);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] rnd_data();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    logic [N*DW-1:0] d;
    logic [N-1:0]    cur_cs;

    initial begin
        reset_ = 1'b0; s_cs_ = '1; s_rdy_ = '1; s_rd_data = '0;
        model(1'b0, '1, '1, '0);

        // reset with random inputs
        step(1'b0, N'($urandom), N'($urandom), rnd_data());
        step(1'b0, N'($urandom), N'($urandom), rnd_data());
        settle();
        chk("rst_rdy",  {63'd0, m_rdy_}, 64'd1);
        chk("rst_data", {32'd0, m_rd_data}, 64'd0);
        chk("rst_err",  {63'd0, m_err}, 64'd0);
        chk("rst_sel",  {61'd0, m_sel}, 64'd0);
        step(1'b1, '1, '1, '0);

        // slave 3 answers after two WAIT cycles
        d = rnd_data();
        d[3*DW +: DW] = 32'hDEADBEEF;
        step(1'b1, ~8'h08, '1, d);
        step(1'b1, ~8'h08, '1, d);
        step(1'b1, ~8'h08, '1, d);
        settle();
        chk("t2_pre_rdy", {63'd0, m_rdy_}, 64'd1);
        step(1'b1, ~8'h08, ~8'h08, d);
        settle();
        chk("t2_rdy",  {63'd0, m_rdy_}, 64'd0);
        chk("t2_data", {32'd0, m_rd_data}, 64'hDEADBEEF);
        chk("t2_sel",  {61'd0, m_sel}, 64'd3);
        chk("t2_err",  {63'd0, m_err}, 64'd0);
        step(1'b1, '1, '1, d);

        // slaves 2 and 5 together; slave 5 rdy_ ignored
        d = rnd_data();
        step(1'b1, ~8'h24, '1, d);
        step(1'b1, ~8'h24, ~8'h20, d);
        step(1'b1, ~8'h24, '1, d);
        step(1'b1, ~8'h24, ~8'h24, d);
        settle();
        chk("t3_sel",  {61'd0, m_sel}, 64'd2);
        chk("t3_data", {32'd0, m_rd_data}, {32'd0, d[2*DW +: DW]});
        step(1'b1, '1, '1, d);

        // watchdog timeout on slave 1
        d = rnd_data();
        step(1'b1, ~8'h02, '1, d);
        for (int i = 0; i < TMO; i++) step(1'b1, ~8'h02, '1, d);
        settle();
        chk("t4_rdy",  {63'd0, m_rdy_}, 64'd0);
        chk("t4_err",  {63'd0, m_err}, 64'd1);
        chk("t4_data", {32'd0, m_rd_data}, 64'd0);
        step(1'b1, '1, '1, d);

        // master abort on slave 0, then a normal access
        step(1'b1, ~8'h01, '1, d);
        step(1'b1, ~8'h01, '1, d);
        step(1'b1, '1, ~8'h01, d);
        step(1'b1, '1, '1, d);
        settle();
        chk("t5_nopulse", {63'd0, m_rdy_}, 64'd1);
        step(1'b1, ~8'h40, ~8'h40, d);
        step(1'b1, ~8'h40, ~8'h40, d);
        settle();
        chk("t5_next", {32'd0, m_rd_data}, {32'd0, d[6*DW +: DW]});
        step(1'b1, '1, '1, d);

        // rdy_ coincides with the timeout cycle
        d = rnd_data();
        step(1'b1, ~8'h10, '1, d);
        for (int i = 0; i < TMO - 1; i++) step(1'b1, ~8'h10, '1, d);
        step(1'b1, ~8'h10, ~8'h10, d);
        settle();
        chk("t6_err",  {63'd0, m_err}, 64'd0);
        chk("t6_data", {32'd0, m_rd_data}, {32'd0, d[4*DW +: DW]});
        step(1'b1, '1, '1, d);

        // reset in the middle of WAIT
        step(1'b1, ~8'h80, '1, d);
        step(1'b1, ~8'h80, '1, d);
        step(1'b0, ~8'h80, ~8'h80, d);
        settle();
        chk("t6_rst_rdy",  {63'd0, m_rdy_}, 64'd1);
        chk("t6_rst_data", {32'd0, m_rd_data}, 64'd0);
        chk("t6_rst_sel",  {61'd0, m_sel}, 64'd0);
        step(1'b1, '1, '1, d);

        // randomized traffic
        cur_cs = '1;
        d = rnd_data();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rdy;
            logic         rst;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: cur_cs = '1;
                    1: cur_cs = N'($urandom);
                    default: cur_cs = ~(N'(1) << $urandom_range(0, N - 1));
                endcase
                d = rnd_data();
            end
            rdy = '1;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) rdy[i] = 1'b0;
            rst = ($urandom_range(0, 99) != 0);
            step(rst, cur_cs, rdy, d);
        end
        @(negedge clk);
        compare_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
